// File: rtl/acq_channel_packer_pkg.sv
// Shared defaults for the acquisition channel packer.
// The index and counter widths are derived from the channel and sample counts.
package acq_pkg;
  localparam int DEF_NCH   = 16;
  localparam int DEF_SPW   = 16;
  localparam int DEF_DIV_W = 8;
  localparam int CH_IDX_W  = $clog2(DEF_NCH);
  localparam int SAMP_W    = $clog2(DEF_SPW);
endpackage

// File: rtl/acq_channel_packer_sample_rate_divider.sv
// Sample strobe generator: strobes when the counter is 0, then counts to div and wraps.
// While clr is high the counter is held at 0, so the first enabled cycle strobes.
module sample_rate_divider
  import acq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);
  logic [DIV_W-1:0] r_div_cnt;

  assign strobe = run & (r_div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (clr) begin
      r_div_cnt <= '0;
    end else if (run) begin
      r_div_cnt <= (r_div_cnt == div) ? '0 : r_div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/acq_channel_packer.sv
// Packs SPW samples per enabled channel into words, double-buffered into a hold bank,
// and streams pending words lowest channel first with a sticky overflow flag.
module acq_channel_packer
  import acq_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int SPW   = DEF_SPW,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acq_enable,
  input  logic                    acq_reset,
  input  logic [DIV_W-1:0]        clock_divisor,
  input  logic [NCH-1:0]          channel_enable,
  input  logic [NCH-1:0]          sample_in,
  output logic [SPW-1:0]          out_data,
  output logic [$clog2(NCH)-1:0]  out_channel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    busy
);
  localparam int IDX_W = $clog2(NCH);
  localparam int SW    = $clog2(SPW);

  logic             r_en_d, r_running, r_overflow;
  logic [SW-1:0]    r_samp_cnt;
  logic [NCH-1:0]   r_mask_q, r_pending;
  logic [DIV_W-1:0] r_div_q;
  logic [SPW-1:0]   r_sreg [NCH];
  logic [SPW-1:0]   r_hold [NCH];
  logic [SPW-1:0]   w_shifted [NCH];

  logic             w_start, w_run, w_clr, w_strobe, w_block_done, w_hs, w_copy_ok;
  logic [NCH-1:0]   w_hs_mask, w_pend_after, w_mask;
  logic [IDX_W-1:0] w_idx;
  logic [DIV_W-1:0] w_div;

  assign w_start = acq_enable & ~r_en_d & ~r_overflow & ~acq_reset;
  assign w_run   = w_start | (r_running & acq_enable);
  assign w_clr   = acq_reset | ~w_run;
  assign w_div   = w_start ? clock_divisor : r_div_q;
  assign w_mask  = w_start ? channel_enable : r_mask_q;

  sample_rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_clr),
    .run    (w_run),
    .div    (w_div),
    .strobe (w_strobe)
  );

  always_comb begin
    w_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = IDX_W'(i);
    end
  end

  // A word accepted on the completing edge frees its slot, so it counts as drained.
  assign w_block_done = w_strobe & (r_samp_cnt == SW'(SPW - 1));
  assign w_hs         = out_valid & out_ready;
  assign w_hs_mask    = w_hs ? (NCH'(1) << w_idx) : '0;
  assign w_pend_after = r_pending & ~w_hs_mask;
  assign w_copy_ok    = (w_pend_after == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign w_shifted[gi] = {sample_in[gi], r_sreg[gi][SPW-1:1]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sreg[gi] <= '0;
          r_hold[gi] <= '0;
        end else if (acq_reset) begin
          r_sreg[gi] <= '0;
          r_hold[gi] <= '0;
        end else begin
          if (w_strobe) r_sreg[gi] <= w_shifted[gi];
          if (w_block_done && w_copy_ok) r_hold[gi] <= w_shifted[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d     <= 1'b0;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      r_pending  <= '0;
      r_samp_cnt <= '0;
      r_mask_q   <= '0;
      r_div_q    <= '0;
    end else if (acq_reset) begin
      r_en_d     <= acq_enable;
      r_running  <= 1'b0;
      r_overflow <= 1'b0;
      r_pending  <= '0;
      r_samp_cnt <= '0;
      r_mask_q   <= '0;
      r_div_q    <= '0;
    end else begin
      r_en_d <= acq_enable;
      if (w_start) begin
        r_running <= 1'b1;
        r_mask_q  <= channel_enable;
        r_div_q   <= clock_divisor;
      end else if (!acq_enable) begin
        r_running <= 1'b0;
      end
      if (w_block_done && !w_copy_ok) begin
        r_overflow <= 1'b1;
        r_running  <= 1'b0;
      end
      r_pending <= (w_block_done && w_copy_ok) ? w_mask : w_pend_after;
      // Idle or a dropped enable discards any partial block.
      if (!w_run)        r_samp_cnt <= '0;
      else if (w_strobe) r_samp_cnt <= r_samp_cnt + 1'b1;
    end
  end

  assign out_valid   = |r_pending;
  assign out_channel = w_idx;
  assign out_data    = out_valid ? r_hold[w_idx] : '0;
  assign overflow    = r_overflow;
  assign busy        = r_running | (|r_pending);
endmodule

// File: tb/tb_acq_channel_packer.sv
// Self-checking bench: a queue-based reference model checked every cycle,
// a table of single-block vectors, and directed multi-cycle corner sequences.
module tb_acq_channel_packer;
  localparam int NC = 16;
  localparam int SP = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          acq_enable = 1'b0;
  logic          acq_reset = 1'b0;
  logic [DW-1:0] clock_divisor = '0;
  logic [NC-1:0] channel_enable = '0;
  logic [NC-1:0] sample_in = '0;
  logic [SP-1:0] out_data;
  logic [3:0]    out_channel;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic          busy;

  always #5 clk = ~clk;

  acq_channel_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .acq_enable     (acq_enable),
    .acq_reset      (acq_reset),
    .clock_divisor  (clock_divisor),
    .channel_enable (channel_enable),
    .sample_in      (sample_in),
    .out_data       (out_data),
    .out_channel    (out_channel),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow),
    .busy           (busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] data;
  } word_t;

  typedef struct {
    logic [3:0]  ch;
    logic [15:0] data;
    int          cyc;
  } obs_t;

  word_t         m_q[$];
  logic [NC-1:0] m_samp[$];
  bit            m_run, m_ovf, m_en_d;
  int            m_t, m_div;
  logic [NC-1:0] m_mask;
  obs_t          d_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_samp.delete();
    m_run = 0;
    m_ovf = 0;
    m_t   = 0;
  endtask

  // Higher-level model: samples collected in a list, a block becomes a queue of words.
  task automatic model_edge();
    bit    hs, start;
    word_t w;
    hs = (m_q.size() > 0) && out_ready;
    if (!rst_n) begin
      model_clear();
      m_en_d = 0;
      return;
    end
    if (acq_reset) begin
      model_clear();
      m_en_d = acq_enable;
      return;
    end
    if (hs) void'(m_q.pop_front());
    start  = acq_enable && !m_en_d && !m_ovf;
    m_en_d = acq_enable;
    if (start) begin
      m_run  = 1;
      m_mask = channel_enable;
      m_div  = int'(clock_divisor);
      m_t    = 0;
      m_samp.delete();
    end
    if (!acq_enable) begin
      m_run = 0;
      m_samp.delete();
    end else if (m_run) begin
      if (m_t % (m_div + 1) == 0) begin
        m_samp.push_back(sample_in);
        if (m_samp.size() == SP) begin
          if (m_q.size() == 0) begin
            for (int c = 0; c < NC; c++) begin
              if (m_mask[c]) begin
                w.ch = 4'(c);
                for (int k = 0; k < SP; k++) w.data[k] = m_samp[k][c];
                m_q.push_back(w);
              end
            end
          end else begin
            m_ovf = 1;
            m_run = 0;
          end
          m_samp.delete();
        end
      end
      m_t++;
    end
  endtask

  task automatic compare();
    bit v;
    v = (m_q.size() > 0);
    check("out_valid", 32'(out_valid), 32'(v));
    check("out_channel", 32'(out_channel), v ? 32'(m_q[0].ch) : 32'd0);
    check("out_data", 32'(out_data), v ? 32'(m_q[0].data) : 32'd0);
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'(m_run || v));
  endtask

  task automatic step();
    obs_t o;
    if (out_valid && out_ready && rst_n && !acq_reset) begin
      o.ch = out_channel;
      o.data = out_data;
      o.cyc = cyc;
      d_log.push_back(o);
    end
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_rst();
    acq_enable = 0;
    acq_reset  = 0;
    out_ready  = 0;
    rst_n      = 0;
    #1;
    model_clear();
    m_en_d = 0;
    compare();
    step();
    step();
    rst_n = 1;
    d_log.delete();
  endtask

  typedef struct {
    logic [7:0]  div;
    logic [15:0] mask;
    logic [15:0] pat;
    logic [3:0]  first_ch;
    logic [3:0]  last_ch;
    int          words;
  } vec_t;

  vec_t vecs[6];
  logic [NC-1:0] blk[$];
  logic [15:0]   expd;
  int            first_ovf;

  initial begin
    vecs[0] = '{8'd0,   16'h0001, 16'h5555, 4'd0,  4'd0,  1};
    vecs[1] = '{8'd3,   16'h8101, 16'h1234, 4'd0,  4'd15, 3};
    vecs[2] = '{8'd1,   16'h0000, 16'hFFFF, 4'd0,  4'd0,  0};
    vecs[3] = '{8'd7,   16'hF000, 16'h8001, 4'd12, 4'd15, 4};
    vecs[4] = '{8'd255, 16'h0400, 16'h0F0F, 4'd10, 4'd10, 1};
    vecs[5] = '{8'd2,   16'hFFFF, 16'hA5C3, 4'd0,  4'd15, 16};

    #2;
    model_clear();
    do_rst();

    // Table vectors: one block, every channel sees the same sample pattern.
    for (int v = 0; v < 6; v++) begin
      do_rst();
      clock_divisor  = vecs[v].div;
      channel_enable = vecs[v].mask;
      out_ready      = 1;
      acq_enable     = 1;
      for (int k = 0; k < SP; k++) begin
        for (int j = 0; j <= int'(vecs[v].div); j++) begin
          sample_in = vecs[v].pat[k] ? '1 : '0;
          if (j == 1) begin
            channel_enable = ~vecs[v].mask;
            clock_divisor  = 8'd0;
          end
          step();
        end
      end
      acq_enable = 0;
      for (int j = 0; j < 40; j++) step();
      check($sformatf("vec%0d_words", v), 32'(d_log.size()), 32'(vecs[v].words));
      if (d_log.size() > 0 && vecs[v].words > 0) begin
        check($sformatf("vec%0d_first_ch", v), 32'(d_log[0].ch), 32'(vecs[v].first_ch));
        check($sformatf("vec%0d_last_ch", v), 32'(d_log[d_log.size()-1].ch), 32'(vecs[v].last_ch));
        check($sformatf("vec%0d_data", v), 32'(d_log[0].data), 32'(vecs[v].pat));
        check($sformatf("vec%0d_back_to_back", v),
              32'(d_log[d_log.size()-1].cyc - d_log[0].cyc), 32'(d_log.size() - 1));
      end
    end

    // Overflow on the 32nd strobe; first block drains intact afterwards.
    do_rst();
    clock_divisor = 0; channel_enable = 16'hFFFF; acq_enable = 1;
    blk.delete();
    first_ovf = 0;
    for (int i = 1; i <= 40; i++) begin
      sample_in = NC'($urandom);
      if (i <= SP) blk.push_back(sample_in);
      step();
      if (overflow && first_ovf == 0) first_ovf = i;
    end
    check("ovf_strobe", 32'(first_ovf), 32'd32);
    out_ready = 1;
    for (int i = 0; i < 20; i++) step();
    check("ovf_drain_words", 32'(d_log.size()), 32'd16);
    for (int i = 0; i < d_log.size(); i++) begin
      for (int k = 0; k < SP; k++) expd[k] = blk[k][i];
      check($sformatf("ovf_drain_ch%0d", i), 32'(d_log[i].ch), 32'(i));
      check($sformatf("ovf_drain_data%0d", i), 32'(d_log[i].data), 32'(expd));
    end
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_idle_busy", 32'(busy), 32'd0);
    acq_reset = 1; acq_enable = 0; step(); acq_reset = 0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Continuous ready: the boundary accept keeps words flowing without overflow.
    do_rst();
    clock_divisor = 0; channel_enable = 16'hFFFF; out_ready = 1; acq_enable = 1;
    for (int i = 0; i < 64; i++) begin
      sample_in = NC'($urandom);
      step();
    end
    check("stream_words", 32'(d_log.size()), 32'd48);
    check("stream_no_ovf", 32'(overflow), 32'd0);

    // Enable dropped mid-block: no word; restart counts from the first sample.
    do_rst();
    clock_divisor = 0; channel_enable = 16'h0001; out_ready = 1; acq_enable = 1;
    for (int i = 0; i < 10; i++) begin
      sample_in = NC'($urandom);
      step();
    end
    acq_enable = 0;
    for (int i = 0; i < 30; i++) step();
    check("partial_discard", 32'(d_log.size()), 32'd0);
    acq_enable = 1;
    for (int i = 0; i < SP; i++) begin
      sample_in = (i == 0) ? 16'h0001 : 16'h0000;
      step();
    end
    acq_enable = 0;
    for (int i = 0; i < 5; i++) step();
    check("restart_words", 32'(d_log.size()), 32'd1);
    if (d_log.size() > 0) check("restart_data", 32'(d_log[0].data), 32'h0001);

    // acq_reset and rst_n mid-emission with overflow set.
    for (int r = 0; r < 2; r++) begin
      do_rst();
      clock_divisor = 0; channel_enable = 16'hFFFF; acq_enable = 1;
      for (int i = 0; i < 34; i++) begin
        sample_in = NC'($urandom);
        step();
      end
      out_ready = 1;
      for (int i = 0; i < 3; i++) step();
      check($sformatf("mid_emit_valid%0d", r), 32'(out_valid), 32'd1);
      if (r == 0) begin
        acq_reset = 1; acq_enable = 0;
        step();
        acq_reset = 0;
        check("acq_reset_valid", 32'(out_valid), 32'd0);
        check("acq_reset_ovf", 32'(overflow), 32'd0);
      end else begin
        rst_n = 0;
        #1;
        check("rstn_async_valid", 32'(out_valid), 32'd0);
        check("rstn_async_ovf", 32'(overflow), 32'd0);
        model_clear();
        m_en_d = 0;
        acq_enable = 0;
        step();
        rst_n = 1;
      end
    end

    // Randomized traffic against the model.
    for (int r = 0; r < 6; r++) begin
      do_rst();
      clock_divisor  = 8'($urandom_range(0, 3));
      channel_enable = ($urandom_range(0, 4) == 0) ? 16'h0000 : NC'($urandom);
      acq_enable     = 1;
      for (int i = 0; i < 400; i++) begin
        sample_in      = NC'($urandom);
        out_ready      = ($urandom_range(0, 9) < 7);
        channel_enable = NC'($urandom);
        clock_divisor  = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) acq_enable = ~acq_enable;
        acq_reset = ($urandom_range(0, 199) == 0);
        step();
      end
      acq_reset = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
